// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
// Parametrised pipeline stage register with a valid/ready handshake.
// With SKID_EN=1 a second (skid) entry lets in_ready come straight from the
// state register, which cuts the combinational ready path through the stage.
// A flush kills every held entry plus any beat accepted in the same cycle.
// The payload registers keep their old contents, and kill_cnt counts the
// killed entries, saturating at its maximum.
module pipe_stage_skid_reg #(
    parameter int WIDTH   = 64,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] kill_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] killCnt_q, killCnt_d;
    logic             inFire;
    logic             outFire;
    logic [1:0]       occupancy;
    logic [1:0]       killed;
    logic [SUM_W-1:0] killSum;

    assign inFire   = in_valid & in_ready;
    assign outFire  = out_valid & out_ready;
    assign out_data = main_q;
    assign kill_cnt = killCnt_q;

    // State, payload and kill counter registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            killCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            killCnt_q <= killCnt_d;
        end
    end

    // Next state and payload moves; a flush empties the stage but keeps the data
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (inFire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (inFire && outFire) begin
                    main_d = in_data;
                end else if (outFire) begin
                    state_d = EMPTY;
                end else if (inFire && (SKID_EN != 0)) begin
                    state_d = TWO;
                    skid_d  = in_data;
                end
            end
            TWO: begin
                if (outFire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // Handshake outputs; the skid variant derives in_ready from state alone
    always_comb begin
        out_valid = (state_q != EMPTY);
        if (SKID_EN != 0) begin
            in_ready = (state_q != TWO);
        end else begin
            in_ready = out_ready | (state_q == EMPTY);
        end
    end

    // Entries killed by a flush this cycle, added to the counter with saturation
    always_comb begin
        case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
        killed    = occupancy + {1'b0, inFire} - {1'b0, outFire};
        killSum   = SUM_W'(killCnt_q) + SUM_W'(killed);
        killCnt_d = killCnt_q;
        if (flush) begin
            if (killSum > SUM_W'(CNT_MAX)) begin
                killCnt_d = CNT_MAX;
            end else begin
                killCnt_d = killSum[CNT_W-1:0];
            end
        end
    end

endmodule
